// File: rtl/fp32_pkg.sv
// Shared FP32 types, constants and operand classification helpers
// for the divider and multiplier datapaths.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam int unsigned FP32_EXP_BIAS = 127;
    localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;

    // One quotient bit per DIV cycle: 24 mantissa bits plus one guard bit
    // so that either normalisation case yields 23 fraction bits.
    localparam int unsigned DIV_ITERS = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } div_state_e;

    // Denormals are flushed: any operand with a zero exponent counts as zero.
    function automatic logic fp32_is_zero(input fp32_t v);
        return (v.exp == 8'h00);
    endfunction

    function automatic logic fp32_is_inf(input fp32_t v);
        return (v.exp == FP32_EXP_MAX) && (v.mant == 23'd0);
    endfunction

    function automatic logic fp32_is_nan(input fp32_t v);
        return (v.exp == FP32_EXP_MAX) && (v.mant != 23'd0);
    endfunction

    function automatic logic [31:0] fp32_inf(input logic sign);
        return {sign, FP32_EXP_MAX, 23'd0};
    endfunction

    function automatic logic [31:0] fp32_zero(input logic sign);
        return {sign, 31'd0};
    endfunction

endpackage

// File: rtl/fp32_divider_if.sv
// Operand/result handshake bundle for the FP32 divider.
// Signal names are seen from the divider side.
interface fp32_divider_if;

    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] res_o;

    // Producer/consumer side driving operands and accepting results.
    modport master (
        output in_valid_i,
        output a_i,
        output b_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  res_o
    );

    // Divider side.
    modport slave (
        input  in_valid_i,
        input  a_i,
        input  b_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output res_o
    );

endinterface

// File: rtl/fp32_special_case.sv
// Combinational classifier for FP32 division operands: flags operand
// pairs whose quotient is fully determined without the mantissa iteration.
module fp32_special_case
    import fp32_pkg::*;
(
    input  fp32_t       a_i,
    input  fp32_t       b_i,
    output logic        hit_o,
    output logic [31:0] res_o
);

    logic a_zero;
    logic a_inf;
    logic a_nan;
    logic b_zero;
    logic b_inf;
    logic b_nan;
    logic sign;

    assign a_zero = fp32_is_zero(a_i);
    assign a_inf  = fp32_is_inf(a_i);
    assign a_nan  = fp32_is_nan(a_i);
    assign b_zero = fp32_is_zero(b_i);
    assign b_inf  = fp32_is_inf(b_i);
    assign b_nan  = fp32_is_nan(b_i);
    assign sign   = a_i.sign ^ b_i.sign;

    // Priority-ordered special-case selection; first match wins.
    always_comb begin
        hit_o = 1'b1;
        res_o = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_o = FP32_QNAN;
        end else if (b_zero) begin
            res_o = fp32_inf(sign);
        end else if (a_inf) begin
            res_o = fp32_inf(sign);
        end else if (a_zero || b_inf) begin
            res_o = fp32_zero(sign);
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/fp32_divider.sv
// Sequential FP32 divider: radix-2 restoring mantissa division, one
// quotient bit per cycle, truncating result, denormals flushed to zero.
module fp32_divider
    import fp32_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    fp32_divider_if.slave bus
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [24:0] rem_q, rem_d;
    logic [24:0] quo_q, quo_d;
    logic [23:0] mb_q, mb_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic        sign_q, sign_d;
    logic [31:0] res_q, res_d;
    logic        out_valid_q, out_valid_d;

    fp32_t       a_in;
    fp32_t       b_in;
    logic        sc_hit;
    logic [31:0] sc_res;

    logic        quo_bit;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    logic signed [9:0] exp_bias;
    logic signed [9:0] exp_norm;
    logic [22:0]       mant_norm;
    logic [31:0]       norm_res;

    assign a_in = bus.a_i;
    assign b_in = bus.b_i;

    assign bus.in_ready_o  = (state_q == ST_IDLE);
    assign bus.out_valid_o = out_valid_q;
    assign bus.res_o       = res_q;

    fp32_special_case u_special (
        .a_i   (a_in),
        .b_i   (b_in),
        .hit_o (sc_hit),
        .res_o (sc_res)
    );

    // One restoring-division step: subtract when the divisor fits, then shift.
    always_comb begin
        quo_bit  = (rem_q >= {1'b0, mb_q});
        rem_sub  = quo_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_next = {rem_sub[23:0], 1'b0};
    end

    // Normalise the 25-bit quotient and clamp the exponent to inf/zero.
    always_comb begin
        if (quo_q[24]) begin
            mant_norm = quo_q[23:1];
            exp_bias  = 10'(FP32_EXP_BIAS);
        end else begin
            mant_norm = quo_q[22:0];
            exp_bias  = 10'(FP32_EXP_BIAS - 1);
        end
        exp_norm = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + exp_bias;
        if (exp_norm >= 10'sd255) begin
            norm_res = fp32_inf(sign_q);
        end else if (exp_norm <= 10'sd0) begin
            norm_res = fp32_zero(sign_q);
        end else begin
            norm_res = {sign_q, exp_norm[7:0], mant_norm};
        end
    end

    // Next-state and datapath register updates for the divider FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        mb_d        = mb_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        sign_d      = sign_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid_i) begin
                    sign_d = a_in.sign ^ b_in.sign;
                    ea_d   = a_in.exp;
                    eb_d   = b_in.exp;
                    mb_d   = {1'b1, b_in.mant};
                    rem_d  = {2'b01, a_in.mant};
                    quo_d  = '0;
                    cnt_d  = '0;
                    if (sc_hit) begin
                        res_d       = sc_res;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                rem_d = rem_next;
                quo_d = {quo_q[23:0], quo_bit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITERS - 1)) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                res_d       = norm_res;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            mb_q        <= '0;
            ea_q        <= '0;
            eb_q        <= '0;
            sign_q      <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            mb_q        <= mb_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            sign_q      <= sign_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Scoreboard bench for fp32_divider: directed vectors with hand-computed
// quotients and latencies; a negedge monitor checks each delivered result.
module tb_fp32_divider;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    logic prev_valid;

    fp32_divider_if dif ();

    fp32_divider dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, value on handshake.
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (dif.out_valid_o && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got res %h with no pending operation", dif.res_o);
                end else begin
                    chk({sb[0].name, "_lat"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
            end
            if (dif.out_valid_o && dif.out_ready_i && sb.size() > 0) begin
                chk(sb[0].name, dif.res_o, sb[0].res);
                void'(sb.pop_front());
            end
        end
        prev_valid = dif.out_valid_o;
    end

    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
        exp_t e;
        bit   accepted;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        dif.in_valid_i = 1'b1;
        dif.a_i        = a;
        dif.b_i        = b;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clk);
            if (dif.in_ready_o) begin
                accepted = 1'b1;
                e.name   = name;
                e.res    = res;
                e.lat    = lat;
                e.acc    = cyc;
                sb.push_back(e);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: in_ready_o never rose, required 1", name);
        end
        @(posedge clk);
        #1;
        dif.in_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (sb.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input int lat);
        issue(name, a, b, res, lat);
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst             = 1'b1;
        dif.in_valid_i  = 1'b0;
        dif.a_i         = '0;
        dif.b_i         = '0;
        dif.out_ready_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, dif.out_valid_o}, 32'd0);
        chk("rst_res", dif.res_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, dif.in_ready_o}, 32'd1);
        chk("post_rst_out_valid", {31'd0, dif.out_valid_o}, 32'd0);
        chk("post_rst_res", dif.res_o, 32'h0);

        // Normal path
        run_vec("div_6_2",      32'h40C00000, 32'h40000000, 32'h40400000, 27);
        run_vec("div_1_3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27);
        run_vec("div_1_1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 27);
        run_vec("div_m6_2",     32'hC0C00000, 32'h40000000, 32'hC0400000, 27);
        run_vec("overflow",     32'h7F000000, 32'h00800000, 32'h7F800000, 27);
        run_vec("underflow",    32'h00800000, 32'h7F000000, 32'h00000000, 27);

        // Special cases
        run_vec("m1_div_0",     32'hBF800000, 32'h00000000, 32'hFF800000, 1);
        run_vec("zero_div_0",   32'h00000000, 32'h00000000, 32'h7FC00000, 1);
        run_vec("denorm_div_1", 32'h00400000, 32'h3F800000, 32'h00000000, 1);
        run_vec("nan_div_1",    32'h7F800001, 32'h3F800000, 32'h7FC00000, 1);
        run_vec("inf_div_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 1);
        run_vec("inf_div_m2",   32'h7F800000, 32'hC0000000, 32'hFF800000, 1);
        run_vec("one_div_minf", 32'h3F800000, 32'hFF800000, 32'h80000000, 1);

        // Backpressure: result held, new operands refused
        @(posedge clk);
        #1;
        dif.out_ready_i = 1'b0;
        issue("bp_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 27);
        for (int k = 0; k < 40 && !dif.out_valid_o; k++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            dif.in_valid_i = 1'b1;
            dif.a_i        = 32'h3F800000;
            dif.b_i        = 32'h3F800000;
            @(negedge clk);
            chk("bp_res_hold", dif.res_o, 32'h40400000);
            chk("bp_valid_hold", {31'd0, dif.out_valid_o}, 32'd1);
            chk("bp_in_ready", {31'd0, dif.in_ready_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        dif.in_valid_i  = 1'b0;
        dif.out_ready_i = 1'b1;
        wait_done("bp_6_2");
        @(posedge clk);
        @(negedge clk);
        chk("bp_after_in_ready", {31'd0, dif.in_ready_o}, 32'd1);
        chk("bp_after_out_valid", {31'd0, dif.out_valid_o}, 32'd0);

        // Reset during iteration 10 of DIV
        issue("rst_mid", 32'h40C00000, 32'h40000000, 32'h40400000, 27);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", {31'd0, dif.out_valid_o}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, dif.in_ready_o}, 32'd1);
        run_vec("after_rst_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 27);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
